// File: rtl/draw_layer_scheduler.sv
// rtl/draw_layer_scheduler.sv - per-pixel draw layer arbiter with frame-synchronous config, blink and collision report
// Optional feature macro: COLLISION_DETECT_EN (sticky collision flags and end-of-frame report).
module draw_layer_scheduler #(
    parameter int         BLINK_FRAMES   = 16,
    parameter logic [7:0] RESET_PRIORITY = 8'b11_10_01_00
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] drawReq,
    input  logic       cfgWrite,
    input  logic [7:0] cfgPriority,
    input  logic [3:0] cfgBlinkMask,
    output logic       layerValid,
    output logic [1:0] layerSel,
    output logic       collisionPulse,
    output logic [3:0] collisionLayers
);

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    logic [7:0] pend_prio_q,   pend_prio_d;
    logic [3:0] pend_mask_q,   pend_mask_d;
    logic       pend_flag_q,   pend_flag_d;
    logic [7:0] act_prio_q,    act_prio_d;
    logic [3:0] act_mask_q,    act_mask_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic       blink_phase_q, blink_phase_d;
    logic       layer_valid_q, layer_valid_d;
    logic [1:0] layer_sel_q,   layer_sel_d;
    logic [3:0] eff_req;

    assign eff_req = drawReq & ~(act_mask_q & {4{blink_phase_q}});

    // Config staging and frame/blink bookkeeping; active config only moves at a frame boundary.
    always_comb begin
        pend_prio_d   = pend_prio_q;
        pend_mask_d   = pend_mask_q;
        pend_flag_d   = pend_flag_q;
        act_prio_d    = act_prio_q;
        act_mask_d    = act_mask_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        if (cfgWrite) begin
            pend_prio_d = cfgPriority;
            pend_mask_d = cfgBlinkMask;
            pend_flag_d = 1'b1;
        end

        if (startOfFrame) begin
            if (cfgWrite) begin
                act_prio_d  = cfgPriority;
                act_mask_d  = cfgBlinkMask;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                act_prio_d  = pend_prio_q;
                act_mask_d  = pend_mask_q;
                pend_flag_d = 1'b0;
            end

            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Slot 0 is scanned first, so the earliest matching slot wins.
    always_comb begin
        layer_valid_d = 1'b0;
        layer_sel_d   = 2'd0;
        for (int s = 0; s < 4; s++) begin
            if (!layer_valid_d && eff_req[act_prio_q[2*s +: 2]]) begin
                layer_valid_d = 1'b1;
                layer_sel_d   = act_prio_q[2*s +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_prio_q   <= RESET_PRIORITY;
            pend_mask_q   <= 4'd0;
            pend_flag_q   <= 1'b0;
            act_prio_q    <= RESET_PRIORITY;
            act_mask_q    <= 4'd0;
            frame_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
            layer_valid_q <= 1'b0;
            layer_sel_q   <= 2'd0;
        end else begin
            pend_prio_q   <= pend_prio_d;
            pend_mask_q   <= pend_mask_d;
            pend_flag_q   <= pend_flag_d;
            act_prio_q    <= act_prio_d;
            act_mask_q    <= act_mask_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            layer_valid_q <= layer_valid_d;
            layer_sel_q   <= layer_sel_d;
        end
    end

    assign layerValid = layer_valid_q;
    assign layerSel   = layer_sel_q;

`ifdef COLLISION_DETECT_EN
    logic [3:0] coll_flags_q,  coll_flags_d;
    logic       coll_pulse_q,  coll_pulse_d;
    logic [3:0] coll_layers_q, coll_layers_d;
    logic [3:0] coll_seen;

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign coll_seen = ((eff_req & (eff_req - 4'd1)) != 4'd0) ? eff_req : 4'd0;

    always_comb begin
        coll_flags_d  = coll_flags_q | coll_seen;
        coll_pulse_d  = 1'b0;
        coll_layers_d = coll_layers_q;
        if (startOfFrame) begin
            if (coll_flags_d != 4'd0) begin
                coll_pulse_d  = 1'b1;
                coll_layers_d = coll_flags_d;
            end
            coll_flags_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_flags_q  <= 4'd0;
            coll_pulse_q  <= 1'b0;
            coll_layers_q <= 4'd0;
        end else begin
            coll_flags_q  <= coll_flags_d;
            coll_pulse_q  <= coll_pulse_d;
            coll_layers_q <= coll_layers_d;
        end
    end

    assign collisionPulse  = coll_pulse_q;
    assign collisionLayers = coll_layers_q;
`else
    assign collisionPulse  = 1'b0;
    assign collisionLayers = 4'd0;
`endif

endmodule

// File: tb/tb_draw_layer_scheduler.sv
// tb/tb_draw_layer_scheduler.sv - randomized and directed check of draw_layer_scheduler against a frame-level model
module tb_draw_layer_scheduler;

    localparam int         BF = 2;
    localparam logic [7:0] RP = 8'b11_10_01_00;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic [3:0] drawReq = 4'd0;
    logic       cfgWrite = 1'b0;
    logic [7:0] cfgPriority = 8'd0;
    logic [3:0] cfgBlinkMask = 4'd0;
    logic       layerValid;
    logic [1:0] layerSel;
    logic       collisionPulse;
    logic [3:0] collisionLayers;

    draw_layer_scheduler #(.BLINK_FRAMES(BF), .RESET_PRIORITY(RP)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawReq(drawReq),
        .cfgWrite(cfgWrite), .cfgPriority(cfgPriority), .cfgBlinkMask(cfgBlinkMask),
        .layerValid(layerValid), .layerSel(layerSel),
        .collisionPulse(collisionPulse), .collisionLayers(collisionLayers)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: frames since reset, slot list, pending/active config, sticky collision set.
    int         m_frames;
    logic [7:0] m_act_prio, m_pend_prio;
    logic [3:0] m_act_mask, m_pend_mask, m_hits, m_eff;
    bit         m_pend_flag;
    int         m_idx;
    logic       exp_valid, exp_pulse;
    logic [1:0] exp_sel;
    logic [3:0] exp_layers;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_frames = 0; m_act_prio = RP; m_pend_prio = RP;
            m_act_mask = 0; m_pend_mask = 0; m_pend_flag = 0; m_hits = 0;
            exp_valid = 0; exp_sel = 0; exp_pulse = 0; exp_layers = 0;
        end else begin
            m_eff = drawReq & ~((((m_frames / BF) % 2) == 1) ? m_act_mask : 4'd0);
            exp_valid = 0; exp_sel = 0;
            for (int s = 0; s < 4; s++) begin
                m_idx = int'((m_act_prio >> (2 * s)) & 8'h3);
                if (!exp_valid && m_eff[m_idx]) begin
                    exp_valid = 1; exp_sel = 2'(m_idx);
                end
            end
`ifdef COLLISION_DETECT_EN
            if ($countones(m_eff) >= 2) m_hits = m_hits | m_eff;
            exp_pulse = 0;
            if (startOfFrame) begin
                if (m_hits != 0) begin exp_pulse = 1; exp_layers = m_hits; end
                m_hits = 0;
            end
`endif
            if (startOfFrame) begin
                m_frames++;
                if (cfgWrite) begin
                    m_act_prio = cfgPriority; m_act_mask = cfgBlinkMask;
                    m_pend_prio = cfgPriority; m_pend_mask = cfgBlinkMask; m_pend_flag = 0;
                end else if (m_pend_flag) begin
                    m_act_prio = m_pend_prio; m_act_mask = m_pend_mask; m_pend_flag = 0;
                end
            end else if (cfgWrite) begin
                m_pend_prio = cfgPriority; m_pend_mask = cfgBlinkMask; m_pend_flag = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {7'd0, layerValid}, {7'd0, exp_valid});
            chk("sel", {6'd0, layerSel}, {6'd0, exp_sel});
            chk("pulse", {7'd0, collisionPulse}, {7'd0, exp_pulse});
            chk("layers", {4'd0, collisionLayers}, {4'd0, exp_layers});
        end
    end

    task automatic cyc(input logic [3:0] req, input logic sof, input logic wr,
                       input logic [7:0] prio, input logic [3:0] mask);
        drawReq = req; startOfFrame = sof; cfgWrite = wr; cfgPriority = prio; cfgBlinkMask = mask;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
    endtask

    task automatic lit_sel(input string nm, input logic v, input logic [1:0] s);
        chk({nm, "_valid"}, {7'd0, layerValid}, {7'd0, v});
        chk({nm, "_sel"}, {6'd0, layerSel}, {6'd0, s});
        chk({nm, "_model"}, {5'd0, exp_valid, exp_sel}, {5'd0, v, s});
    endtask

    int blink_exp[6] = '{0, 2, 2, 0, 0, 2};

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        lit_sel("reset", 1'b0, 2'd0);
        chk("reset_pulse", {7'd0, collisionPulse}, 8'd0);
        chk("reset_layers", {4'd0, collisionLayers}, 8'd0);
        resetN = 1'b1;

        cyc(4'b1010, 0, 0, 8'd0, 4'd0);  lit_sel("r033a", 1'b1, 2'd1);
        cyc(4'b0000, 0, 0, 8'd0, 4'd0);  lit_sel("r033b", 1'b0, 2'd0);

        cyc(4'b1001, 0, 1, 8'b00_01_10_11, 4'd0); lit_sel("r034_wr", 1'b1, 2'd0);
        cyc(4'b1001, 0, 0, 8'd0, 4'd0);           lit_sel("r034_mid", 1'b1, 2'd0);
        cyc(4'b1001, 1, 0, 8'd0, 4'd0);           lit_sel("r034_sof", 1'b1, 2'd0);
        cyc(4'b1001, 0, 0, 8'd0, 4'd0);           lit_sel("r034_new", 1'b1, 2'd3);

        cyc(4'b1001, 0, 1, 8'b01_00_11_10, 4'd0); lit_sel("r036_pre", 1'b1, 2'd3);
        cyc(4'b1001, 1, 1, RP, 4'd0);             lit_sel("r036_sof", 1'b1, 2'd3);
        cyc(4'b1001, 0, 0, 8'd0, 4'd0);           lit_sel("r036_new", 1'b1, 2'd0);
        cyc(4'b1001, 1, 0, 8'd0, 4'd0);
        cyc(4'b1001, 0, 0, 8'd0, 4'd0);           lit_sel("r036_hold", 1'b1, 2'd0);

        pulse_reset();
        cyc(4'b0101, 1, 1, RP, 4'b0001);          lit_sel("r035_cfg", 1'b1, 2'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(4'b0101, 0, 0, 8'd0, 4'd0); lit_sel("r035_a", 1'b1, 2'(blink_exp[k]));
            cyc(4'b0101, 0, 0, 8'd0, 4'd0); lit_sel("r035_b", 1'b1, 2'(blink_exp[k]));
            cyc(4'b0101, 1, 0, 8'd0, 4'd0); lit_sel("r035_c", 1'b1, 2'(blink_exp[k]));
        end

        pulse_reset();
        cyc(4'b0011, 0, 0, 8'd0, 4'd0); lit_sel("r037_hit", 1'b1, 2'd0);
        cyc(4'b0000, 0, 0, 8'd0, 4'd0);
        cyc(4'b0000, 1, 0, 8'd0, 4'd0);
`ifdef COLLISION_DETECT_EN
        chk("r037_pulse", {7'd0, collisionPulse}, 8'd1);
        chk("r037_layers", {4'd0, collisionLayers}, 8'h03);
`else
        chk("r037_pulse_off", {7'd0, collisionPulse}, 8'd0);
`endif
        cyc(4'b0000, 0, 0, 8'd0, 4'd0);
        chk("r037_one", {7'd0, collisionPulse}, 8'd0);
        cyc(4'b0000, 1, 0, 8'd0, 4'd0);
        chk("r037_clean", {7'd0, collisionPulse}, 8'd0);
`ifdef COLLISION_DETECT_EN
        chk("r037_hold", {4'd0, collisionLayers}, 8'h03);
`else
        chk("r037_hold_off", {4'd0, collisionLayers}, 8'h00);
`endif

        cyc(4'b0000, 1, 1, 8'b00_01_10_11, 4'd0);
        cyc(4'b0011, 0, 0, 8'd0, 4'd0);           lit_sel("r038_pre", 1'b1, 2'd1);
        pulse_reset();
        cyc(4'b0001, 1, 0, 8'd0, 4'd0);
        chk("r038_pulse", {7'd0, collisionPulse}, 8'd0);
        chk("r038_layers", {4'd0, collisionLayers}, 8'd0);
        cyc(4'b1001, 0, 0, 8'd0, 4'd0);           lit_sel("r038_prio", 1'b1, 2'd0);

        for (int i = 0; i < 4000; i++) begin
            cyc(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                8'($urandom), 4'($urandom));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                pulse_reset();
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
